// File: rtl/mips_load_store_unit.sv
// Load/store initiator for a word-organised data memory: byte/half/word accesses,
// read-modify-write for sub-word stores, big-endian lane selection.
module mips_load_store_unit #(
    parameter int MEM_INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, next_state;
    logic [31:0] addr_q, wdata_q, buf_q;
    logic [1:0]  size_q;
    logic        signed_q, write_q, err_q;
    logic        accept, req_err;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, merged;

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == SZ_HALF) && req_addr[0])
                | ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                | ((req_addr >> (MEM_INDEX_BITS + 2)) != 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_valid) begin
                if (req_err)                                   next_state = RESP;
                else if (req_write && (req_size == SZ_WORD))   next_state = WRITE;
                else                                           next_state = READ;
            end
            READ:  next_state = write_q ? WRITE : RESP;
            WRITE: next_state = RESP;
            RESP:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                err_q    <= req_err;
            end
            if (state == READ) buf_q <= mem_rdata;
        end
    end

    // Big-endian: byte offset 0 lives in the top lane, so the shift is (3 - offset) lanes.
    assign byte_sh = {~addr_q[1:0], 3'b000};
    assign half_sh = {~addr_q[1], 4'b0000};
    assign ld_byte = 8'(buf_q >> byte_sh);
    assign ld_half = 16'(buf_q >> half_sh);

    always_comb begin
        case (size_q)
            SZ_BYTE: ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = buf_q;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: merged = (buf_q & ~(32'h0000_00FF << byte_sh)) | ({24'd0, wdata_q[7:0]} << byte_sh);
            SZ_HALF: merged = (buf_q & ~(32'h0000_FFFF << half_sh)) | ({16'd0, wdata_q[15:0]} << half_sh);
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        req_ready        = (state == IDLE);
        mem_read_enable  = (state == READ);
        mem_write_enable = (state == WRITE);
        mem_addr         = (state == IDLE) ? 32'd0 : {2'b00, addr_q[31:2]};
        mem_wdata        = (state == WRITE) ? merged : 32'd0;
        resp_valid       = (state == RESP);
        resp_error       = (state == RESP) && err_q;
        resp_rdata       = ((state == RESP) && !err_q && !write_q) ? ld_ext : 32'd0;
    end
endmodule

// File: tb/tb_mips_load_store_unit.sv
// Bench for mips_load_store_unit: directed table, reset/handshake sequences and
// random traffic checked against a byte-addressed big-endian reference model.
module tb_mips_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write_enable, mem_read_enable;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  rb  [0:1023];

    int          n_rd, n_wr, bad_wd;
    logic [31:0] wd_seen;

    mips_load_store_unit #(.MEM_INDEX_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_read_enable ? mem[mem_addr[7:0]] : 32'd0;

    always @(negedge clk) if (mem_write_enable) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {rb[4*idx], rb[4*idx+1], rb[4*idx+2], rb[4*idx+3]};
    endfunction

    // Reference: memory seen as a byte array, MSB byte first.
    function automatic void ref_op(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic err, output int lat,
                                   output logic [31:0] wword, output int nrd, output int nwr);
        int b;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd1024);
        rd = 0; wword = 0; nrd = 0; nwr = 0; lat = 1;
        if (err) return;
        b = int'(a[9:0]);
        if (!w) begin
            nrd = 1; lat = 2;
            case (sz)
                2'd0:    rd = {{24{sg & rb[b][7]}}, rb[b]};
                2'd1:    rd = {{16{sg & rb[b][7]}}, rb[b], rb[b+1]};
                default: rd = {rb[b], rb[b+1], rb[b+2], rb[b+3]};
            endcase
        end else begin
            nwr = 1;
            case (sz)
                2'd0: begin rb[b] = wd[7:0]; nrd = 1; lat = 3; end
                2'd1: begin rb[b] = wd[15:8]; rb[b+1] = wd[7:0]; nrd = 1; lat = 3; end
                default: begin
                    rb[b] = wd[31:24]; rb[b+1] = wd[23:16]; rb[b+2] = wd[15:8]; rb[b+3] = wd[7:0];
                    lat = 2;
                end
            endcase
            wword = ref_word(b / 4);
        end
    endfunction

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 8) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble request fields after acceptance; they must be ignored.
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        n_rd = 0; n_wr = 0; wd_seen = 0; lat = 1;
        while (1) begin
            if (mem_read_enable) n_rd++;
            if (mem_write_enable) begin n_wr++; wd_seen = mem_wdata; end
            else if (mem_wdata != 32'd0) bad_wd++;
            if (resp_valid || lat >= 8) break;
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_error;
    endtask

    task automatic run_op(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        logic [31:0] x_rd, x_ww;
        logic        x_er;
        int          x_lat, x_nrd, x_nwr;
        ref_op(w, sz, sg, a, wd, x_rd, x_er, x_lat, x_ww, x_nrd, x_nwr);
        issue(w, sz, sg, a, wd, rd, er, lat);
        chk({nm, ".rdata"}, rd, x_rd);
        chk({nm, ".error"}, 32'(er), 32'(x_er));
        chk({nm, ".latency"}, 32'(lat), 32'(x_lat));
        chk({nm, ".reads"}, 32'(n_rd), 32'(x_nrd));
        chk({nm, ".writes"}, 32'(n_wr), 32'(x_nwr));
        if (x_nwr != 0) chk({nm, ".wdata"}, wd_seen, x_ww);
        if (!x_er) chk({nm, ".memword"}, mem[a[9:2]], ref_word(int'(a[9:2])));
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] x_rd;
        logic        x_err;
        int          x_lat;
        logic [31:0] x_wd;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [31:0] rd, d1, d2, x1, x2, w3, xw, junk;
        logic        er, xe;
        int          lat, xl, xr, xn, seen_rv;
        logic [5:1]  rdy, rv;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h0};
        vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2, 32'h11223344};
        vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h123456AA, 32'h0,        1'b0, 3, 32'h1122AA44};
        vt[4]  = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h1122AA44, 1'b0, 2, 32'h0};
        vt[5]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 2, 32'h80FF7F01};
        vt[6]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h0};
        vt[7]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000080, 1'b0, 2, 32'h0};
        vt[8]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00007F01, 1'b0, 2, 32'h0};
        vt[9]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'hFFFF80FF, 1'b0, 2, 32'h0};
        vt[10] = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vt[11] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 32'h0};
        vt[12] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,       32'h0,        1'b1, 1, 32'h0};
        vt[13] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFEBEEF, 32'h0,        1'b0, 3, 32'h80FFBEEF};
        vt[14] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h00000055, 32'h0,        1'b0, 3, 32'h80FFBE55};
        vt[15] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000055, 1'b0, 2, 32'h0};
        vt[16] = '{1'b1, 2'd2, 1'b0, 32'h11, 32'h12345678, 32'h0,        1'b1, 1, 32'h0};
        vt[17] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h00001234, 32'h0,        1'b1, 1, 32'h0};

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]} = mem[i];
        end
        bad_wd = 0;
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        reset = 1'b1;
        #12;
        chk("reset.outputs",
            {21'd0, req_ready, resp_valid, resp_error, mem_write_enable, mem_read_enable, 6'd0},
            {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        chk("reset.buses", resp_rdata | mem_addr | mem_wdata, 32'd0);
        #10 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, rd, er, lat);
            chk($sformatf("vec%0d.table_rdata", i), rd, vt[i].x_rd);
            chk($sformatf("vec%0d.table_error", i), 32'(er), 32'(vt[i].x_err));
            chk($sformatf("vec%0d.table_latency", i), 32'(lat), 32'(vt[i].x_lat));
            if (vt[i].w && !vt[i].x_err) chk($sformatf("vec%0d.table_wdata", i), wd_seen, vt[i].x_wd);
        end

        // Reset pulse inside the WRITE cycle of a word store to index 3.
        w3 = mem[3];
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'd2; req_signed = 0;
        req_addr = 32'hC; req_wdata = ~w3;
        @(posedge clk); #1;
        req_valid = 0;
        chk("rst_abort.in_write", 32'(mem_write_enable), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_abort.flags",
            {26'd0, req_ready, resp_valid, resp_error, mem_write_enable, mem_read_enable, 1'b0},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("rst_abort.buses", resp_rdata | mem_addr | mem_wdata, 32'd0);
        #1 reset = 1'b0;
        seen_rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen_rv++;
        end
        chk("rst_abort.word3", mem[3], w3);
        chk("rst_abort.no_resp", 32'(seen_rv), 32'd0);
        chk("rst_abort.ready", 32'(req_ready), 32'd1);

        // Handshake: req_valid held high across two back-to-back loads.
        ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, x1, xe, xl, xw, xr, xn);
        ref_op(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, x2, xe, xl, xw, xr, xn);
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h14;
        d1 = 0; d2 = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 4) begin req_valid = 0; req_addr = 32'h18; req_write = 1; end
            rdy[c] = req_ready; rv[c] = resp_valid;
            if (c == 2) d1 = resp_rdata;
            if (c == 5) d2 = resp_rdata;
        end
        chk("hs.ready_seq", 32'(rdy), 32'(5'b00100));
        chk("hs.valid_seq", 32'(rv), 32'(5'b10010));
        chk("hs.first_data", d1, x1);
        chk("hs.second_data", d2, x2);
        req_write = 0;

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {22'd0, 10'($urandom)};
            if ($urandom_range(0, 15) == 0) a[$urandom_range(10, 31)] = 1'b1;
            run_op($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   rd, er, lat);
        end
        junk = 32'(bad_wd);
        chk("wdata_zero_outside_write", junk, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
